// File: rtl/spi_mem_pkg.sv
// Shared command codes, FSM states and sizes for the SPI master that talks to
// the SPI slave + RAM memory wrapper.
package spi_mem_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    WAIT,
    RX,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI master: a parallel-load MOSI shift register and a MISO
// shift-in register.
module spi_master_shifter
  import spi_mem_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_loadWord,
  input  logic                  i_shift,
  input  logic                  i_capture,
  input  logic                  i_miso,
  output logic                  o_mosi,
  output logic [7:0]            o_rxNext
);

  logic [FRAME_BITS-1:0] r_tx;
  logic [6:0]            r_rx;

  // Zeros shift in behind the frame, so MOSI idles low once all bits are out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_loadWord;
      end else if (i_shift) begin
        r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
      end
      if (i_capture) begin
        r_rx <= {r_rx[5:0], i_miso};
      end
    end
  end

  assign o_mosi = r_tx[FRAME_BITS-1];
  // Byte as it stands once the current MISO bit is included.
  assign o_rxNext = {r_rx, i_miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the memory wrapper: one host request per frame, serialised as
// 2 command bits + 8 payload bits, with an 8-bit MISO read for read-data frames.
module spi_master_ctrl
  import spi_mem_pkg::*;
#(
  parameter int RD_DELAY   = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_payload,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_WAIT_LAST = CNT_W'(RD_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [1:0]       r_cmd;
  logic             r_ssN;
  logic             r_ready;
  logic             r_busy;
  logic             r_rspValid;
  logic [7:0]       r_rspData;
  logic             w_accept;
  logic             w_lastRx;
  logic [7:0]       w_rxNext;
  logic [FRAME_BITS-1:0] w_loadWord;

  assign w_accept   = req_valid && r_ready;
  assign w_loadWord = {req_cmd, (req_cmd == CMD_RD_DATA) ? 8'h00 : req_payload};

  // Next state and per-state cycle counter; the counter restarts on every state change.
  always_comb begin
    w_nextState = r_state;
    w_lastRx    = 1'b0;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = CMD;
      CMD:     if (r_cnt == CNT_CMD_LAST) begin
                 if (r_cmd != CMD_RD_DATA) w_nextState = PAYLOAD;
                 else if (RD_DELAY > 0)    w_nextState = WAIT;
                 else                      w_nextState = RX;
               end
      PAYLOAD: if (r_cnt == CNT_BYTE_LAST) w_nextState = GAP;
      WAIT:    if (r_cnt == CNT_WAIT_LAST) w_nextState = RX;
      RX:      if (r_cnt == CNT_BYTE_LAST) begin
                 w_nextState = GAP;
                 w_lastRx    = 1'b1;
               end
      GAP:     if (r_cnt == CNT_GAP_LAST) w_nextState = w_accept ? CMD : IDLE;
      default: w_nextState = IDLE;
    endcase
    w_nextCnt = ((w_nextState != r_state) || (r_state == IDLE)) ? '0 : r_cnt + CNT_W'(1);
  end

  // Ready/busy/SS_n are registered from the next state so they line up with the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cmd      <= 2'b00;
      r_ssN      <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= 8'h00;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) r_cmd <= req_cmd;
      r_ssN      <= (w_nextState == IDLE) || (w_nextState == GAP);
      r_ready    <= (w_nextState == IDLE) ||
                    ((w_nextState == GAP) && (w_nextCnt == CNT_GAP_LAST));
      r_busy     <= (w_nextState != IDLE);
      r_rspValid <= w_lastRx;
      if (w_lastRx) r_rspData <= w_rxNext;
    end
  end

  spi_master_shifter u_shifter (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_accept),
    .i_loadWord (w_loadWord),
    .i_shift    (r_state != IDLE),
    .i_capture  (r_state == RX),
    .i_miso     (MISO),
    .o_mosi     (MOSI),
    .o_rxNext   (w_rxNext)
  );

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign SS_n      = r_ssN;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: host requests in, a behavioural model of
// the SPI memory wrapper on the pins, and scoreboards for frames and read responses.
module tb_spi_master_ctrl;
  import spi_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_payload;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy, SS_n, MOSI, MISO;

  logic       rv1, rr1, rspV1, busy1, ss1, mosi1, miso1;
  logic [1:0] rc1;
  logic [7:0] rp1, rspD1;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         cyc = 0;
  int         lastAccept;
  bit         streaming;
  logic [9:0] expFrames[$];
  logic [7:0] expRsp[$];
  logic [7:0] expMem[256];
  logic [7:0] expAddr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl #(.RD_DELAY(0), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_payload(req_payload), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master_ctrl #(.RD_DELAY(1), .GAP_CYCLES(1)) dutDelay (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
    .req_cmd(rc1), .req_payload(rp1), .rsp_valid(rspV1),
    .rsp_data(rspD1), .busy(busy1), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model of the wrapper: tracks address/memory and queues expected results.
  function automatic void pushExpect(input logic [1:0] cmd, input logic [7:0] pay);
    expFrames.push_back({cmd, (cmd == CMD_RD_DATA) ? 8'h00 : pay});
    case (cmd)
      CMD_WR_ADDR, CMD_RD_ADDR: expAddr = pay;
      CMD_WR_DATA:              expMem[expAddr] = pay;
      default:                  expRsp.push_back(expMem[expAddr]);
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] pay);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_payload = pay;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    pushExpect(cmd, pay);
    @(posedge clk); #1;
    if (streaming && lastAccept >= 0) checkOutput("req_period", cyc - lastAccept, 11);
    lastAccept = cyc;
    req_valid = 1'b0;
  endtask

  // Slave memory wrapper on the RD_DELAY=0 instance; MISO set at negedge of each cycle.
  initial begin : slaveModel
    int         sBit;
    logic [1:0] sCmd;
    logic [7:0] sShift, sAddr, rdByte;
    logic [7:0] slaveMem[256];
    for (int i = 0; i < 256; i++) slaveMem[i] = 8'h00;
    sBit = 0; sCmd = 2'b00; sShift = 8'h00; sAddr = 8'h00; MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        sBit = 0;
        MISO = 1'b0;
      end else begin
        MISO = 1'b0;
        if (sBit < 2) begin
          sCmd = {sCmd[0], MOSI};
        end else if (sBit <= 9) begin
          sShift = {sShift[6:0], MOSI};
          if (sCmd == CMD_RD_DATA) begin
            rdByte = slaveMem[sAddr];
            MISO = rdByte[3'(9 - sBit)];
          end
          if (sBit == 9) begin
            case (sCmd)
              CMD_WR_ADDR, CMD_RD_ADDR: sAddr = sShift;
              CMD_WR_DATA:              slaveMem[sAddr] = sShift;
              default: ;
            endcase
          end
        end
        sBit++;
      end
    end
  end

  // Turnaround slave for the RD_DELAY=1 instance: 0xA5 on frame cycles 3..10.
  initial begin : slaveDelayModel
    int         b;
    logic [7:0] pat;
    b = 0; pat = 8'hA5; miso1 = 1'b0;
    forever begin
      @(negedge clk);
      if (ss1 !== 1'b0) begin
        b = 0;
        miso1 = 1'b0;
      end else begin
        miso1 = (b >= 3 && b <= 10) ? pat[3'(10 - b)] : 1'b0;
        b++;
      end
    end
  end

  initial begin : frameMonitor
    int         len;
    logic [9:0] bits;
    logic [9:0] expBits;
    len = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        len = 0;
        bits = '0;
      end else if (SS_n === 1'b0) begin
        bits = {bits[8:0], MOSI};
        len++;
      end else if (len > 0) begin
        checkOutput("ss_low_cycles", len, 10);
        if (expFrames.size() == 0) begin
          checkOutput("unexpected_frame", 32'd0, 32'd1);
        end else begin
          expBits = expFrames.pop_front();
          checkOutput("mosi_frame", {22'd0, bits}, {22'd0, expBits});
        end
        checkOutput("mosi_gap", MOSI, 1'b0);
        len = 0;
      end
    end
  end

  initial begin : rspMonitor
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (expRsp.size() == 0) checkOutput("unexpected_rsp", 32'd0, 32'd1);
        else checkOutput("rsp_data", rsp_data, expRsp.pop_front());
      end
    end
  end

  initial begin
    int guard;
    int lowCnt;
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'b00; req_payload = 8'h00;
    rv1 = 1'b0; rc1 = 2'b00; rp1 = 8'h00;
    lastAccept = -1; streaming = 1'b0; expAddr = 8'h00;
    for (int i = 0; i < 256; i++) expMem[i] = 8'h00;

    repeat (2) @(posedge clk); #1;
    checkOutput("reset_ss_n", SS_n, 1'b1);
    checkOutput("reset_mosi", MOSI, 1'b0);
    checkOutput("reset_ready", req_ready, 1'b1);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 8'h00);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;

    applyStimulus(CMD_WR_ADDR, 8'h64);
    applyStimulus(CMD_WR_DATA, 8'h0B);
    applyStimulus(CMD_RD_ADDR, 8'h64);
    applyStimulus(CMD_RD_DATA, 8'h00);
    applyStimulus(CMD_WR_DATA, 8'hA5);
    applyStimulus(CMD_RD_DATA, 8'h5A);

    // Request held valid with a changing payload: only the latched one goes out.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_WR_DATA; req_payload = 8'h3C; guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("hold_first_ready", req_ready, 1'b1);
    pushExpect(CMD_WR_DATA, 8'h3C);
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checkOutput("hold_ready", req_ready, (k == 10));
      checkOutput("hold_busy", busy, 1'b1);
      if (k < 10) req_payload = 8'($urandom);
    end
    pushExpect(CMD_WR_DATA, req_payload);
    @(posedge clk); #1;
    req_valid = 1'b0;
    applyStimulus(CMD_RD_DATA, 8'h00);

    // Reset in cycle 5 of a read-data frame, with a nonzero rsp_data beforehand.
    applyStimulus(CMD_WR_DATA, 8'hC3);
    applyStimulus(CMD_RD_DATA, 8'h00);
    applyStimulus(CMD_RD_DATA, 8'h00);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_ss_n", SS_n, 1'b1);
    checkOutput("midrst_mosi", MOSI, 1'b0);
    checkOutput("midrst_ready", req_ready, 1'b1);
    checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midrst_rsp_data", rsp_data, 8'h00);
    checkOutput("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    void'(expFrames.pop_back());
    void'(expRsp.pop_back());

    streaming = 1'b1;
    lastAccept = -1;
    for (int n = 0; n < 100; n++) begin
      applyStimulus(CMD_WR_ADDR, 8'(100 + n));
      applyStimulus(CMD_WR_DATA, 8'(11 * ((n % 23) + 1)));
    end
    for (int n = 0; n < 100; n++) begin
      applyStimulus(CMD_RD_ADDR, 8'(100 + n));
      applyStimulus(CMD_RD_DATA, 8'h00);
    end
    streaming = 1'b0;

    // RD_DELAY=1 instance: one extra turnaround cycle before MISO sampling.
    @(negedge clk);
    rv1 = 1'b1; rc1 = CMD_RD_DATA; rp1 = 8'hFF;
    @(posedge clk); #1;
    rv1 = 1'b0;
    lowCnt = 0; guard = 0;
    @(negedge clk);
    while (ss1 === 1'b0 && guard < 30) begin
      lowCnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("delay_ss_low_cycles", lowCnt, 11);
    checkOutput("delay_rsp_valid", rspV1, 1'b1);
    checkOutput("delay_rsp_data", rspD1, 8'hA5);
    @(negedge clk);
    checkOutput("delay_rsp_pulse", rspV1, 1'b0);

    repeat (15) @(negedge clk);
    checkOutput("frames_pending", expFrames.size(), 0);
    checkOutput("rsp_pending", expRsp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
